// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
// Byte FIFO feeding the UART transmitter: single-strobe writes in, one byte per
// frame out through a registered TxEnable launch pulse, with sticky overflow.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [7:0]            WrData,
    input  logic                  WrEnable,
    input  logic                  ClearOverflow,
    output logic                  Full,
    output logic                  Empty,
    output logic [DEPTH_LOG2:0]   Count,
    output logic                  Overflow,
    output logic [7:0]            TxDataOutput,
    output logic                  TxEnable,
    input  logic                  TxReady
);
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, DONE} state_e;

    state_e                  state_q, state_d;
    logic [7:0]              mem_q [0:(1<<DEPTH_LOG2)-1];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     count_q, count_d;
    logic                    ovf_q, ovf_d;
    logic                    tx_en_q, tx_en_d;
    logic [7:0]              tx_data_q, tx_data_d;
    logic                    pop, accept, reject;

    // A pop frees a slot in the same cycle, so a full FIFO can still take a write.
    always_comb begin
        pop    = (state_q == IDLE) && (count_q != '0) && TxReady;
        accept = WrEnable && ((count_q != DEPTH_CNT) || pop);
        reject = WrEnable && !accept;
    end

    always_comb begin
        wr_ptr_d  = accept ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
        rd_ptr_d  = pop    ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
        tx_data_d = pop    ? mem_q[rd_ptr_q] : tx_data_q;
        count_d   = count_q;
        case ({accept, pop})
            2'b10:   count_d = count_q + (DEPTH_LOG2+1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LOG2+1)'(1);
            default: count_d = count_q;
        endcase
        // A dropped write outranks a clear in the same cycle.
        ovf_d = reject ? 1'b1 : (ClearOverflow ? 1'b0 : ovf_q);
    end

    always_comb begin
        state_d = state_q;
        tx_en_d = 1'b0;
        case (state_q)
            IDLE: if (pop) begin
                state_d = LAUNCH;
                tx_en_d = 1'b1;
            end
            LAUNCH:  state_d = BUSY;
            BUSY:    if (!TxReady) state_d = DONE;
            DONE:    if (TxReady)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            tx_en_q   <= 1'b0;
            tx_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge Clk) begin
        if (accept) mem_q[wr_ptr_q] <= WrData;
    end

    assign Count        = count_q;
    assign Full         = (count_q == DEPTH_CNT);
    assign Empty        = (count_q == '0);
    assign Overflow     = ovf_q;
    assign TxEnable     = tx_en_q;
    assign TxDataOutput = tx_data_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
// Directed bench for uart_tx_fifo with a simple transmitter model that drops
// TxReady for tx_frame cycles after each launch.
module tb_uart_tx_fifo;
    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] WrData = 8'h00;
    logic       WrEnable = 1'b0;
    logic       ClearOverflow = 1'b0;
    logic       Full, Empty, Overflow, TxEnable, TxReady;
    logic [4:0] Count;
    logic [7:0] TxDataOutput;

    int tests = 0;
    int fails = 0;

    logic [7:0] got[$];
    int         pulses = 0;
    int         tx_frame = 10;
    logic       tx_hold = 1'b0;
    int         busy_cnt;

    uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
        .Clk(Clk), .Reset(Reset), .WrData(WrData), .WrEnable(WrEnable),
        .ClearOverflow(ClearOverflow), .Full(Full), .Empty(Empty), .Count(Count),
        .Overflow(Overflow), .TxDataOutput(TxDataOutput), .TxEnable(TxEnable),
        .TxReady(TxReady)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) busy_cnt <= 0;
        else if (TxEnable) begin
            got.push_back(TxDataOutput);
            pulses = pulses + 1;
            busy_cnt <= tx_frame;
        end else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign TxReady = !tx_hold && (busy_cnt == 0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk); #1;
    endtask

    task automatic wr(input logic [7:0] b);
        WrData = b; WrEnable = 1'b1;
        step();
        WrEnable = 1'b0;
    endtask

    task automatic wait_drain(input int n, input int budget);
        for (int c = 0; c < budget && !(pulses == n && TxReady && Empty); c++) step();
        repeat (3) step();
        chk("pulse_count", pulses, n);
    endtask

    task automatic chk_order(input string tag, input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++)
            chk(tag, (i < got.size()) ? {24'h0, got[i]} : 32'hxxxx_xxxx, {24'h0, first + 8'(i)});
    endtask

    initial begin
        repeat (2) step();
        chk("rst_count", Count, 0);
        chk("rst_empty", Empty, 1);
        chk("rst_full", Full, 0);
        chk("rst_ovf", Overflow, 0);
        chk("rst_txen", TxEnable, 0);
        chk("rst_txdata", TxDataOutput, 8'h00);
        Reset = 1'b1;
        step();

        // Single byte: visible after the write edge, launched at the next one.
        wr(8'hA5);
        chk("t1_count_w", Count, 1);
        chk("t1_empty_w", Empty, 0);
        chk("t1_txen_w", TxEnable, 0);
        step();
        chk("t1_txen", TxEnable, 1);
        chk("t1_txdata", TxDataOutput, 8'hA5);
        chk("t1_count_p", Count, 0);
        step();
        chk("t1_txen_off", TxEnable, 0);
        wait_drain(1, 100);
        chk_order("t1_data", 8'hA5, 1);
        chk("t1_empty", Empty, 1);

        // Burst of 16 against a slow transmitter.
        got.delete(); pulses = 0; tx_frame = 100;
        for (int i = 0; i < 16; i++) wr(8'(i));
        wait_drain(16, 2500);
        chk_order("t2_order", 8'h00, 16);
        chk("t2_ovf", Overflow, 0);

        // Fill with transmitter held busy, overflow, clear priority.
        got.delete(); pulses = 0; tx_frame = 20; tx_hold = 1'b1;
        for (int i = 0; i < 16; i++) wr(8'h10 + 8'(i));
        chk("t3_full", Full, 1);
        chk("t3_count", Count, 16);
        chk("t3_ovf0", Overflow, 0);
        wr(8'hEE);
        chk("t3_ovf", Overflow, 1);
        chk("t3_count_drop", Count, 16);
        ClearOverflow = 1'b1;
        wr(8'hEF);
        chk("t3_ovf_prio", Overflow, 1);
        step();
        ClearOverflow = 1'b0;
        chk("t3_ovf_clr", Overflow, 0);

        // Write in the same cycle as a pop from a full FIFO.
        tx_hold = 1'b0;
        wr(8'h99);
        chk("t4_count", Count, 16);
        chk("t4_ovf", Overflow, 0);
        chk("t4_txen", TxEnable, 1);
        chk("t4_txdata", TxDataOutput, 8'h10);
        wait_drain(17, 1500);
        chk_order("t4_order", 8'h10, 16);
        chk("t4_last", (got.size() > 16) ? {24'h0, got[16]} : 32'hxxxx_xxxx, 8'h99);

        // Asynchronous reset mid-frame with 5 bytes still queued.
        got.delete(); pulses = 0; tx_frame = 50; tx_hold = 1'b1;
        for (int i = 0; i < 6; i++) wr(8'h40 + 8'(i));
        tx_hold = 1'b0;
        step();
        chk("t5_txen_pre", TxEnable, 1);
        chk("t5_count_pre", Count, 5);
        #2 Reset = 1'b0;
        #1;
        chk("t5_txen_rst", TxEnable, 0);
        chk("t5_count_rst", Count, 0);
        chk("t5_empty_rst", Empty, 1);
        chk("t5_txdata_rst", TxDataOutput, 8'h00);
        step();
        Reset = 1'b1;
        repeat (20) step();
        chk("t5_no_launch", pulses, 0);
        chk("t5_count_post", Count, 0);

        // 20 bytes while draining; pointers wrap past the end of storage.
        got.delete(); pulses = 0; tx_frame = 3;
        for (int i = 0; i < 20; i++) begin
            wr(8'h60 + 8'(i));
            step();
        end
        wait_drain(20, 500);
        chk_order("t6_order", 8'h60, 20);
        chk("t6_count", Count, 0);
        chk("t6_ovf", Overflow, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
